// File: rtl/keypad_scan4x4_if.sv
// rtl/keypad_scan4x4_if.sv - keypad scanner signal bundle
interface keypad_scan4x4_if;
  logic [3:0]  row;
  logic        clr;
  logic [3:0]  col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_pressed;
  logic [31:0] data;

  modport master (
    output row, clr,
    input  col, key_code, key_valid, key_pressed, data
  );

  modport slave (
    input  row, clr,
    output col, key_code, key_valid, key_pressed, data
  );
endinterface

// File: rtl/keypad_scan4x4.sv
// rtl/keypad_scan4x4.sv - 4x4 active-low keypad scanner with frame debounce
module keypad_scan4x4 #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scan4x4_if.slave   kp
);
  localparam int          DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0]  DF    = 4'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_idx_q;
  logic [1:0]       col_idx_d;
  logic [3:0]       col_q;
  logic [3:0]       row_meta_q;
  logic [3:0]       row_sync_q;
  logic [3:0]       frame_q [4];
  logic             eval_q;
  logic             tick;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [3:0]       stored_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_pressed_q;
  logic [31:0]      data_q;

  logic [4:0]       frame_lows;
  logic [3:0]       frame_cand;
  logic             frame_hit;

  assign tick      = (div_q == DIV_W'(SCAN_DIV - 1));
  assign col_idx_d = col_idx_q + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q      <= '0;
      col_idx_q  <= 2'd0;
      col_q      <= 4'b1110;
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
      eval_q     <= 1'b0;
      for (int c = 0; c < 4; c++) frame_q[c] <= 4'b1111;
    end else begin
      row_meta_q <= kp.row;
      row_sync_q <= row_meta_q;
      // Evaluation runs one clock after the column-3 sample lands in the buffer
      eval_q     <= tick && (col_idx_q == 2'd3);
      if (tick) begin
        div_q              <= '0;
        frame_q[col_idx_q] <= row_sync_q;
        col_idx_q          <= col_idx_d;
        col_q              <= ~(4'b0001 << col_idx_d);
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  // Any frame with more than one closed contact is a ghost/multi-key and ignored
  always_comb begin
    frame_lows = 5'd0;
    frame_cand = 4'd0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (!frame_q[c][r]) begin
          frame_lows = frame_lows + 5'd1;
          frame_cand = 4'(r * 4 + c);
        end
      end
    end
    frame_hit = (frame_lows == 5'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      stored_q      <= 4'd0;
      key_code_q    <= 4'd0;
      key_valid_q   <= 1'b0;
      key_pressed_q <= 1'b0;
      data_q        <= 32'd0;
    end else begin
      key_valid_q <= 1'b0;
      if (eval_q) begin
        case (state_q)
          IDLE: begin
            if (frame_hit) begin
              stored_q <= frame_cand;
              if (DF == 4'd1) begin
                key_code_q    <= frame_cand;
                key_valid_q   <= 1'b1;
                key_pressed_q <= 1'b1;
                data_q        <= {data_q[27:0], frame_cand};
                cnt_q         <= 4'd0;
                state_q       <= HELD;
              end else begin
                cnt_q   <= 4'd1;
                state_q <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (frame_hit && (frame_cand == stored_q)) begin
              if (cnt_q + 4'd1 == DF) begin
                key_code_q    <= stored_q;
                key_valid_q   <= 1'b1;
                key_pressed_q <= 1'b1;
                data_q        <= {data_q[27:0], stored_q};
                cnt_q         <= 4'd0;
                state_q       <= HELD;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else begin
              cnt_q   <= 4'd0;
              state_q <= IDLE;
            end
          end
          HELD: begin
            if (!frame_hit) begin
              if (DF == 4'd1) begin
                key_pressed_q <= 1'b0;
                cnt_q         <= 4'd0;
                state_q       <= IDLE;
              end else begin
                cnt_q   <= 4'd1;
                state_q <= RELEASE;
              end
            end
          end
          default: begin
            if (!frame_hit) begin
              if (cnt_q + 4'd1 == DF) begin
                key_pressed_q <= 1'b0;
                cnt_q         <= 4'd0;
                state_q       <= IDLE;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end else begin
              cnt_q   <= 4'd0;
              state_q <= HELD;
            end
          end
        endcase
      end
      // Placed last so a clear beats a same-cycle shift-in
      if (kp.clr) data_q <= 32'd0;
    end
  end

  assign kp.col         = col_q;
  assign kp.key_code    = key_code_q;
  assign kp.key_valid   = key_valid_q;
  assign kp.key_pressed = key_pressed_q;
  assign kp.data        = data_q;
endmodule

// File: tb/tb_keypad_scan4x4.sv
// tb/tb_keypad_scan4x4.sv - directed self-checking bench for keypad_scan4x4
module tb_keypad_scan4x4;
  logic        clk;
  logic        reset;
  logic [15:0] pressed;
  logic        ovr;
  int          checks;
  int          failures;
  int          vcount;
  int          base;
  bit          dbl;
  logic        kv_prev;

  keypad_scan4x4_if kp ();

  keypad_scan4x4 #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kp.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Matrix model: a closed key pulls its row low while its column is driven low
  always_comb begin
    kp.row = 4'b1111;
    if (ovr) begin
      kp.row = 4'b0000;
    end else begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (pressed[r*4+c] && !kp.col[c]) kp.row[r] = 1'b0;
    end
  end

  initial begin
    vcount  = 0;
    dbl     = 1'b0;
    kv_prev = 1'b0;
  end

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) begin
      vcount = vcount + 1;
      if (kv_prev === 1'b1) dbl = 1'b1;
    end
    kv_prev = kp.key_valid;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_frames(input int n);
    repeat (n * 16) @(posedge clk);
    #1;
  endtask

  task automatic sync_frame();
    logic [3:0] prev;
    bit found;
    found = 1'b0;
    prev  = kp.col;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk);
      #1;
      if (kp.col == 4'b1110 && prev == 4'b0111) found = 1'b1;
      prev = kp.col;
    end
    check("sync_frame", 32'(found), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    ovr      = 1'b1;
    pressed  = 16'd0;
    kp.clr   = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_col", 32'(kp.col), 32'h0000000e);
    check("rst_valid", 32'(kp.key_valid), 32'd0);
    check("rst_pressed", 32'(kp.key_pressed), 32'd0);
    check("rst_data", kp.data, 32'd0);
    check("rst_code", 32'(kp.key_code), 32'd0);
    reset = 1'b0;
    ovr   = 1'b0;
    repeat (4) @(posedge clk); #1;
    check("rot_col1", 32'(kp.col), 32'h0000000d);
    repeat (4) @(posedge clk); #1;
    check("rot_col2", 32'(kp.col), 32'h0000000b);
    repeat (4) @(posedge clk); #1;
    check("rot_col3", 32'(kp.col), 32'h00000007);
    repeat (4) @(posedge clk); #1;
    check("rot_col0", 32'(kp.col), 32'h0000000e);

    // Single press of r1,c2 -> code 6, accepted at the third frame evaluation
    sync_frame();
    base = vcount;
    pressed[6] = 1'b1;
    repeat (48) @(posedge clk); #1;
    check("single_pre_valid", 32'(kp.key_valid), 32'd0);
    @(posedge clk); #1;
    check("single_valid", 32'(kp.key_valid), 32'd1);
    check("single_code_early", 32'(kp.key_code), 32'd6);
    repeat (47) @(posedge clk); #1;
    check("single_count", 32'(vcount - base), 32'd1);
    check("single_code", 32'(kp.key_code), 32'd6);
    check("single_data", kp.data, 32'h00000006);
    check("single_held", 32'(kp.key_pressed), 32'd1);
    pressed = 16'd0;
    wait_frames(3);
    check("release_still_held", 32'(kp.key_pressed), 32'd1);
    @(posedge clk); #1;
    check("release_done", 32'(kp.key_pressed), 32'd0);

    // Bounce on r0,c0: 2 frames, gap, 2 frames
    sync_frame();
    base = vcount;
    pressed[0] = 1'b1;
    wait_frames(2);
    pressed = 16'd0;
    wait_frames(1);
    pressed[0] = 1'b1;
    wait_frames(2);
    pressed = 16'd0;
    wait_frames(2);
    check("bounce_count", 32'(vcount - base), 32'd0);
    check("bounce_pressed", 32'(kp.key_pressed), 32'd0);
    check("bounce_data", kp.data, 32'h00000006);

    // Two keys in different rows/columns are rejected
    base = vcount;
    pressed[9]  = 1'b1;
    pressed[15] = 1'b1;
    wait_frames(5);
    check("multi_count", 32'(vcount - base), 32'd0);
    check("multi_data", kp.data, 32'h00000006);
    check("multi_pressed", 32'(kp.key_pressed), 32'd0);
    pressed = 16'd0;
    wait_frames(1);

    kp.clr = 1'b1;
    @(posedge clk); #1;
    kp.clr = 1'b0;
    check("clr_data", kp.data, 32'd0);

    base = vcount;
    for (int k = 1; k <= 3; k++) begin
      sync_frame();
      pressed[k] = 1'b1;
      wait_frames(4);
      pressed = 16'd0;
      wait_frames(4);
    end
    check("seq_count", 32'(vcount - base), 32'd3);
    check("seq_data", kp.data, 32'h00000123);
    check("seq_code", 32'(kp.key_code), 32'd3);

    // clr lands on the same edge that accepts key 0xA
    sync_frame();
    pressed[10] = 1'b1;
    repeat (48) @(posedge clk); #1;
    kp.clr = 1'b1;
    @(posedge clk); #1;
    kp.clr = 1'b0;
    check("clrA_valid", 32'(kp.key_valid), 32'd1);
    check("clrA_code", 32'(kp.key_code), 32'h0000000a);
    check("clrA_data", kp.data, 32'd0);
    @(posedge clk); #1;
    check("clrA_valid_drop", 32'(kp.key_valid), 32'd0);
    pressed = 16'd0;
    wait_frames(5);
    check("clrA_released", 32'(kp.key_pressed), 32'd0);

    // Reset during debounce of key 5; key stays held and must re-debounce
    sync_frame();
    base = vcount;
    pressed[5] = 1'b1;
    wait_frames(2);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_col", 32'(kp.col), 32'h0000000e);
    check("mid_rst_code", 32'(kp.key_code), 32'd0);
    check("mid_rst_pressed", 32'(kp.key_pressed), 32'd0);
    check("mid_rst_data", kp.data, 32'd0);
    repeat (48) @(posedge clk); #1;
    check("mid_pre_count", 32'(vcount - base), 32'd0);
    @(posedge clk); #1;
    check("mid_valid", 32'(kp.key_valid), 32'd1);
    check("mid_code", 32'(kp.key_code), 32'd5);
    check("mid_data", kp.data, 32'h00000005);
    pressed = 16'd0;
    wait_frames(5);
    check("mid_total", 32'(vcount - base), 32'd1);
    check("valid_never_double", 32'(dbl), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
